// File: rtl/alarm_ctrl.sv
// Multi-slot alarm controller: per-slot alarm times with enable, ring/snooze/dismiss
// FSM with ring timeout and snooze expiry, and a blinking flash pattern while ringing.
module alarm_ctrl #(
  parameter int NUM_ALARMS        = 4,
  parameter int FLASH_WIDTH       = 16,
  parameter int SNOOZE_MINS       = 5,
  parameter int RING_TIMEOUT_MINS = 10,
  parameter int BLINK_DIV         = 25000000,
  localparam int IDX_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             mins_value,
  input  logic [5:0]             hours_value,
  input  logic                   minute_tick,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [5:0]             cfg_mins,
  input  logic [5:0]             cfg_hours,
  input  logic                   cfg_enable,
  input  logic                   snooze,
  input  logic                   dismiss,
  output logic [FLASH_WIDTH-1:0] flash,
  output logic                   ringing,
  output logic                   snoozed,
  output logic [IDX_W-1:0]       active_idx
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t             state;
  logic               slot_en    [NUM_ALARMS];
  logic [5:0]         slot_mins  [NUM_ALARMS];
  logic [5:0]         slot_hours [NUM_ALARMS];
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic [5:0]         ring_min_cnt;
  logic [5:0]         snooze_cnt;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               kill;

  // Lowest-index enabled slot whose time equals the current time.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!hit && slot_en[i] && slot_mins[i] == mins_value && slot_hours[i] == hours_value) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign kill = cfg_we && !cfg_enable && (cfg_idx == active_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        slot_en[i]    <= 1'b0;
        slot_mins[i]  <= '0;
        slot_hours[i] <= '0;
      end
      state        <= IDLE;
      flash        <= '0;
      ringing      <= 1'b0;
      snoozed      <= 1'b0;
      active_idx   <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      ring_min_cnt <= '0;
      snooze_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          slot_en[i]    <= cfg_enable;
          slot_mins[i]  <= cfg_mins;
          slot_hours[i] <= cfg_hours;
        end
      end

      case (state)
        IDLE: begin
          if (minute_tick && hit) begin
            active_idx   <= hit_idx;
            state        <= RINGING;
            ringing      <= 1'b1;
            snoozed      <= 1'b0;
            flash        <= '1;
            phase        <= 1'b1;
            blink_cnt    <= '0;
            ring_min_cnt <= '0;
          end
        end

        RINGING: begin
          if (kill || dismiss) begin
            state   <= IDLE;
            ringing <= 1'b0;
            snoozed <= 1'b0;
            flash   <= '0;
          end else if (snooze) begin
            state      <= SNOOZED;
            ringing    <= 1'b0;
            snoozed    <= 1'b1;
            flash      <= '0;
            snooze_cnt <= 6'(SNOOZE_MINS);
          end else begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
              blink_cnt <= '0;
              phase     <= ~phase;
              flash     <= {FLASH_WIDTH{~phase}};
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            // Timeout overrides the blink update made above.
            if (minute_tick) begin
              if (ring_min_cnt == 6'(RING_TIMEOUT_MINS - 1)) begin
                state   <= IDLE;
                ringing <= 1'b0;
                flash   <= '0;
              end else begin
                ring_min_cnt <= ring_min_cnt + 1'b1;
              end
            end
          end
        end

        SNOOZED: begin
          if (kill || dismiss) begin
            state   <= IDLE;
            ringing <= 1'b0;
            snoozed <= 1'b0;
            flash   <= '0;
          end else if (minute_tick) begin
            if (snooze_cnt == 6'd1) begin
              state        <= RINGING;
              ringing      <= 1'b1;
              snoozed      <= 1'b0;
              flash        <= '1;
              phase        <= 1'b1;
              blink_cnt    <= '0;
              ring_min_cnt <= '0;
            end else begin
              snooze_cnt <= snooze_cnt - 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          ringing <= 1'b0;
          snoozed <= 1'b0;
          flash   <= '0;
        end
      endcase
    end
  end

endmodule
